taxi_state_decoder: RTL and testbench

- Decodes the packed 9-bit Taxi environment state index into its four fields: taxi row, taxi column, passenger location and destination.
- Sits between the environment state register and the policy/reward logic of the FPGA Taxi agent.
- Packing rule: state = ((taxi_row*N_COLS + taxi_col)*N_PASS + pass_idx)*N_DEST + dest_idx.
- Outputs are registered, with a simple valid qualifier and an out-of-range flag.

---
 rtl/taxi_state_decoder_if.sv | 70 +++++++
 rtl/taxi_state_decoder.sv | 91 +++++++++
 tb/tb_taxi_state_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/taxi_state_decoder_if.sv
// Payload type and bus interface for the Taxi state decoder.
// The package holds the decoded-state record that the decoder registers.
// The interface groups the input handshake (in_valid, encoded_state) and
// the decoded result (out_valid, dest_idx, pass_idx, taxi_col, taxi_row,
// in_taxi, state_err).
// Modports:
//   master - the producer of encoded states and consumer of decoded fields
//   slave  - the decoder itself

package taxi_state_decoder_pkg;

  localparam int unsigned STATE_W = 9;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned PASS_W  = 3;
  localparam int unsigned DEST_W  = 2;

  // One decoded state as it sits in the output register.
  typedef struct packed {
    logic [ROW_W-1:0]  taxi_row;
    logic [COL_W-1:0]  taxi_col;
    logic [PASS_W-1:0] pass_idx;
    logic [DEST_W-1:0] dest_idx;
    logic              in_taxi;
    logic              state_err;
  } decoded_t;

endpackage : taxi_state_decoder_pkg

interface taxi_state_decoder_if;
  import taxi_state_decoder_pkg::*;

  // Input side
  logic                in_valid;
  logic [STATE_W-1:0]  encoded_state;

  // Result side
  logic                out_valid;
  logic [DEST_W-1:0]   dest_idx;
  logic [PASS_W-1:0]   pass_idx;
  logic [COL_W-1:0]    taxi_col;
  logic [ROW_W-1:0]    taxi_row;
  logic                in_taxi;
  logic                state_err;

  modport master (
    output in_valid,
    output encoded_state,
    input  out_valid,
    input  dest_idx,
    input  pass_idx,
    input  taxi_col,
    input  taxi_row,
    input  in_taxi,
    input  state_err
  );

  modport slave (
    input  in_valid,
    input  encoded_state,
    output out_valid,
    output dest_idx,
    output pass_idx,
    output taxi_col,
    output taxi_row,
    output in_taxi,
    output state_err
  );

endinterface : taxi_state_decoder_if

// File: rtl/taxi_state_decoder.sv
// Taxi state decoder: splits the packed environment state index
//   state = ((taxi_row*N_COLS + taxi_col)*N_PASS + pass_idx)*N_DEST + dest_idx
// into its four fields with a single registered stage (1-cycle latency,
// one result per cycle, no backpressure).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every output
//   bus    - slave side of taxi_state_decoder_if
//            in:  in_valid, encoded_state
//            out: out_valid, dest_idx, pass_idx, taxi_col, taxi_row,
//                 in_taxi, state_err
// Indices at or beyond N_ROWS*N_COLS*N_PASS*N_DEST raise state_err with all
// fields forced to zero; out_valid still asserts so the consumer sees it.

module taxi_state_decoder
  import taxi_state_decoder_pkg::*;
#(
  parameter int unsigned N_ROWS = 5,
  parameter int unsigned N_COLS = 5,
  parameter int unsigned N_PASS = 5,
  parameter int unsigned N_DEST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  taxi_state_decoder_if.slave   bus
);

  localparam int unsigned N_TOTAL = N_ROWS * N_COLS * N_PASS * N_DEST;
  // One extra bit so N_TOTAL = 512 is representable in the range compare.
  localparam int unsigned CMP_W   = STATE_W + 1;

  // Decode stage signals
  logic [STATE_W-1:0] state_c;
  logic [STATE_W-1:0] q1_c;
  logic [STATE_W-1:0] q2_c;
  logic               range_err_c;
  decoded_t           dec_next_c;

  // Output register
  logic               out_valid_q;
  decoded_t           dec_q;

  // Constant-divisor split of the packed index, evaluated every cycle.
  always_comb begin
    state_c     = bus.encoded_state;
    q1_c        = '0;
    q2_c        = '0;
    range_err_c = 1'b0;
    dec_next_c  = '0;

    q1_c = state_c / STATE_W'(N_DEST);
    q2_c = q1_c / STATE_W'(N_PASS);

    range_err_c = ({1'b0, state_c} >= CMP_W'(N_TOTAL));

    if (range_err_c) begin
      dec_next_c.state_err = 1'b1;
    end else begin
      dec_next_c.dest_idx  = DEST_W'(state_c % STATE_W'(N_DEST));
      dec_next_c.pass_idx  = PASS_W'(q1_c % STATE_W'(N_PASS));
      dec_next_c.taxi_col  = COL_W'(q2_c % STATE_W'(N_COLS));
      dec_next_c.taxi_row  = ROW_W'(q2_c / STATE_W'(N_COLS));
      // Registered alongside pass_idx so it always matches the held value.
      dec_next_c.in_taxi   = (dec_next_c.pass_idx == PASS_W'(N_PASS - 1));
      dec_next_c.state_err = 1'b0;
    end
  end

  // Result register: valid follows in_valid, fields hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        dec_q <= dec_next_c;
      end
    end
  end

  // Drive the interface straight from the register.
  assign bus.out_valid = out_valid_q;
  assign bus.dest_idx  = dec_q.dest_idx;
  assign bus.pass_idx  = dec_q.pass_idx;
  assign bus.taxi_col  = dec_q.taxi_col;
  assign bus.taxi_row  = dec_q.taxi_row;
  assign bus.in_taxi   = dec_q.in_taxi;
  assign bus.state_err = dec_q.state_err;

endmodule : taxi_state_decoder

// File: tb/tb_taxi_state_decoder.sv
// Self-checking bench for taxi_state_decoder: directed steps from the test
// plan followed by random states checked against a packing-rule model.

module tb_taxi_state_decoder;

  localparam int NR = 5;
  localparam int NC = 5;
  localparam int NP = 5;
  localparam int ND = 4;
  localparam int TOTAL = NR * NC * NP * ND;

  logic clk;
  logic rst_n;

  taxi_state_decoder_if bus ();

  taxi_state_decoder #(
    .N_ROWS (NR),
    .N_COLS (NC),
    .N_PASS (NP),
    .N_DEST (ND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Expected output state
  int exp_valid;
  int exp_row;
  int exp_col;
  int exp_pass;
  int exp_dest;
  int exp_taxi;
  int exp_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
    chk({tag, ".taxi_row"},  32'(bus.taxi_row),  32'(exp_row));
    chk({tag, ".taxi_col"},  32'(bus.taxi_col),  32'(exp_col));
    chk({tag, ".pass_idx"},  32'(bus.pass_idx),  32'(exp_pass));
    chk({tag, ".dest_idx"},  32'(bus.dest_idx),  32'(exp_dest));
    chk({tag, ".in_taxi"},   32'(bus.in_taxi),   32'(exp_taxi));
    chk({tag, ".state_err"}, 32'(bus.state_err), 32'(exp_err));
  endtask

  // Reference: find the field tuple whose packing equals s.
  function automatic void model(input int s, output int r, output int c,
                                output int p, output int d, output int it,
                                output int err);
    r = 0; c = 0; p = 0; d = 0; it = 0;
    err = (s >= TOTAL) ? 1 : 0;
    if (err == 0) begin
      for (int rr = 0; rr < NR; rr++)
        for (int cc = 0; cc < NC; cc++)
          for (int pp = 0; pp < NP; pp++)
            for (int dd = 0; dd < ND; dd++)
              if (((rr * NC + cc) * NP + pp) * ND + dd == s) begin
                r = rr; c = cc; p = pp; d = dd;
              end
      it = (p == NP - 1) ? 1 : 0;
    end
  endfunction

  // Drive one cycle, then check the registered result just after the edge.
  task automatic step_exp(input string tag, input bit v, input int s,
                          input int r, input int c, input int p,
                          input int d, input int it, input int err);
    @(negedge clk);
    bus.in_valid      = v;
    bus.encoded_state = 9'(s);
    @(posedge clk);
    #1;
    exp_valid = v ? 1 : 0;
    if (v) begin
      exp_row = r; exp_col = c; exp_pass = p; exp_dest = d;
      exp_taxi = it; exp_err = err;
    end
    check_all(tag);
  endtask

  task automatic step_model(input string tag, input bit v, input int s);
    int r, c, p, d, it, err;
    model(s, r, c, p, d, it, err);
    step_exp(tag, v, s, r, c, p, d, it, err);
  endtask

  task automatic clear_exp();
    exp_valid = 0; exp_row = 0; exp_col = 0; exp_pass = 0;
    exp_dest = 0; exp_taxi = 0; exp_err = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_exp();
    rst_n             = 1'b0;
    bus.in_valid      = 1'b1;
    bus.encoded_state = 9'd211;

    // Reset dominates a valid input
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed test-plan steps
    step_exp("s0",   1'b1, 0,   0, 0, 0, 0, 0, 0);
    step_exp("s211", 1'b1, 211, 2, 0, 2, 3, 0, 0);
    step_exp("s328", 1'b1, 328, 3, 1, 2, 0, 0, 0);
    step_exp("s499", 1'b1, 499, 4, 4, 4, 3, 1, 0);
    step_exp("s17",  1'b1, 17,  0, 0, 4, 1, 1, 0);
    step_exp("s500", 1'b1, 500, 0, 0, 0, 0, 0, 1);
    step_exp("s511", 1'b1, 511, 0, 0, 0, 0, 0, 1);
    step_exp("s211b", 1'b1, 211, 2, 0, 2, 3, 0, 0);
    // Idle: fields hold, out_valid drops (encoded_state changes are ignored)
    step_exp("idle", 1'b0, 499, 0, 0, 0, 0, 0, 0);
    step_exp("idle2", 1'b0, 17, 0, 0, 0, 0, 0, 0);

    // Async reset between edges while out_valid=1
    step_exp("pre_rst", 1'b1, 499, 4, 4, 4, 3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step_exp("post_rst", 1'b1, 211, 2, 0, 2, 3, 0, 0);

    // Random states and valid pattern against the model
    for (int i = 0; i < 300; i++) begin
      int s;
      bit v;
      s = int'($urandom_range(0, 511));
      v = ($urandom_range(0, 3) != 0);
      step_model("rand", v, s);
    end

    // Boundary sweep around the last legal index
    step_model("b498", 1'b1, 498);
    step_model("b499", 1'b1, 499);
    step_model("b500", 1'b1, 500);
    step_model("b0",   1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_taxi_state_decoder
